alarm_ringer: RTL and testbench
===============================

// Module: alarm_ringer
// PURPOSE
//  Consumer of the Alarm match output: turns the level "time == alarm time" into a ringing session.
//  Detects the match edge, drives a beeping buzzer and supports snooze/stop with a bounded snooze count.
//  Auto-silences after a timeout.
//  Sits between Alarm.out, the 1 Hz timebase and the buzzer/LED pins.
// PARAMETERS
//  RING_SECS    60    seconds a ring session lasts before auto-timeout (>=1)
//  SNOOZE_SECS  300   seconds spent in snooze before re-ringing (>=1, < 2**CNT_W)
//  MAX_SNOOZES  3     snoozes allowed per alarm event (1..7)
//  TONE_HALF    25000 clk cycles per buzzer tone half-period (>=1)
//  CNT_W        9     width of seconds counter / secs_left
// PORTS
//  clk          in   1      system clock
//  reset        in   1      synchronous, active-high reset
//  tick_1hz     in   1      one-clk strobe per second from timebase
//  alarm_hit    in   1      level from Alarm.out (high for whole matching second)
//  enable       in   1      alarm armed; low forces IDLE
//  snooze       in   1      one-clk pulse (debounced upstream)
//  stop         in   1      one-clk pulse (debounced upstream)
//  buzzer       out  1      gated tone square wave, registered
//  ringing      out  1      high in RING
//  snoozing     out  1      high in SNOOZE
//  snoozes_used out  3      snoozes consumed this event
//  secs_left    out  CNT_W  seconds remaining in current RING/SNOOZE, 0 in IDLE
//  missed       out  1      sticky: last event timed out unanswered
// BEHAVIOUR
//  Reset: state=IDLE; buzzer, ringing, snoozing, snoozes_used, secs_left and missed all 0.
//  Reset also clears hit_d and the tone counter. Reset mid-RING/SNOOZE silences in the next cycle.
//  trigger = alarm_hit & ~hit_d & enable. hit_d is a register of alarm_hit. Only rising edges count.
//  Every state/output changes on posedge clk. ringing rises on the edge where trigger is seen.
//  Therefore ringing is high 1 cycle after alarm_hit goes high.
//  IDLE:
//   - trigger -> RING, secs_left=RING_SECS, snoozes_used=0, missed=0.
//  RING (precedence top-down):
//   - ~enable or stop -> IDLE, missed=0.
//   - snooze & snoozes_used<MAX_SNOOZES -> SNOOZE, secs_left=SNOOZE_SECS, snoozes_used+1.
//   - snooze with snoozes_used==MAX_SNOOZES is ignored and ringing continues.
//   - tick & secs_left==1 -> IDLE, missed=1.
//   - tick otherwise -> secs_left-1.
//  SNOOZE (precedence top-down):
//   - ~enable or stop -> IDLE.
//   - snooze ignored.
//   - tick & secs_left==1 -> RING, secs_left=RING_SECS.
//   - tick otherwise -> secs_left-1.
//  trigger while in RING/SNOOZE is ignored (no restart, counters untouched).
//  stop and snooze in the same cycle: stop wins. stop/snooze and tick in the same cycle: the button wins, tick is dropped.
//  Tone:
//   - tone_cnt counts 0..TONE_HALF-1 only in RING and wraps; the tone bit toggles on wrap.
//   - Counter and tone are held at 0 outside RING.
//  Beep phase:
//   - beep_on is set to 1 on every RING entry.
//   - It toggles on each tick while in RING (1 s on / 1 s off).
//  buzzer (registered) = RING & beep_on & tone. buzzer=0 in the cycle after leaving RING.
//  secs_left never wraps below 0. Counters are sized so RING_SECS/SNOOZE_SECS fit CNT_W with no overflow.
//  missed keeps its value until the next trigger from IDLE, or until reset.
// TESTING (bench params: RING_SECS=4, SNOOZE_SECS=3, MAX_SNOOZES=2, TONE_HALF=2)
//  1. reset 3 cycles -> all outputs 0. Then raise alarm_hit with enable=1.
//     -> ringing=1 next cycle, secs_left=4. buzzer toggles every 2 clks while beep_on.
//  2. Ring with no input, 4 ticks -> IDLE after 4th tick, missed=1, buzzer=0.
//     Hold alarm_hit high throughout -> no retrigger.
//  3. snooze in RING -> snoozing=1, secs_left=3, snoozes_used=1.
//     3 ticks -> ringing=1, secs_left=4. snooze again -> snoozes_used=2.
//     After 3 ticks, a 3rd snooze is ignored and ringing stays 1.
//  4. stop and snooze in the same cycle during RING -> IDLE, snoozes_used not incremented, missed=0.
//     stop coincident with the final tick -> IDLE, missed=0.
//  5. enable=0 during SNOOZE -> IDLE next cycle. alarm_hit edge with enable=0 -> stays IDLE.
//  6. reset asserted mid-RING with buzzer high -> buzzer=0, ringing=0, secs_left=0 next cycle.

Source files
------------

// File: rtl/alarm_ringer_if.sv
// Signal bundle between the alarm/timebase side and the ringer: control strobes in,
// buzzer/status out. CNT_W must match the ringer's CNT_W.
interface alarm_ringer_if #(
    parameter int CNT_W = 9
);
    logic             tick_1hz;
    logic             alarm_hit;
    logic             enable;
    logic             snooze;
    logic             stop;
    logic             buzzer;
    logic             ringing;
    logic             snoozing;
    logic [2:0]       snoozes_used;
    logic [CNT_W-1:0] secs_left;
    logic             missed;

    modport master (
        output tick_1hz, alarm_hit, enable, snooze, stop,
        input  buzzer, ringing, snoozing, snoozes_used, secs_left, missed
    );

    modport slave (
        input  tick_1hz, alarm_hit, enable, snooze, stop,
        output buzzer, ringing, snoozing, snoozes_used, secs_left, missed
    );
endinterface

// File: rtl/alarm_ringer.sv
// Alarm ringer: turns the rising edge of the alarm match level into a ring session with
// beeping tone, bounded snooze, stop, and auto-timeout that flags a missed alarm.
module alarm_ringer #(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int MAX_SNOOZES = 3,
    parameter int TONE_HALF   = 25000,
    parameter int CNT_W       = 9
) (
    input  logic          clk,
    input  logic          reset,
    alarm_ringer_if.slave bus
);
    localparam int TW = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;

    typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

    state_t          state;
    logic            hit_d;
    logic [TW-1:0]   tone_cnt;
    logic            tone;
    logic            beep_on;

    logic            trigger;
    logic            tone_wrap;
    logic            tone_next;
    logic            beep_next;

    assign trigger   = bus.alarm_hit & ~hit_d & bus.enable;
    assign tone_wrap = (tone_cnt == TW'(TONE_HALF - 1));
    assign tone_next = tone ^ tone_wrap;
    assign beep_next = beep_on ^ bus.tick_1hz;

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            hit_d            <= 1'b0;
            tone_cnt         <= '0;
            tone             <= 1'b0;
            beep_on          <= 1'b0;
            bus.buzzer       <= 1'b0;
            bus.ringing      <= 1'b0;
            bus.snoozing     <= 1'b0;
            bus.snoozes_used <= 3'd0;
            bus.secs_left    <= '0;
            bus.missed       <= 1'b0;
        end else begin
            hit_d <= bus.alarm_hit;
            // Tone and buzzer are silent unless the stay-in-RING path below overrides them,
            // so every exit from RING reads buzzer=0 on the very next cycle.
            bus.buzzer <= 1'b0;
            tone_cnt   <= '0;
            tone       <= 1'b0;

            case (state)
                IDLE: begin
                    if (trigger) begin
                        state            <= RING;
                        bus.ringing      <= 1'b1;
                        bus.secs_left    <= CNT_W'(RING_SECS);
                        bus.snoozes_used <= 3'd0;
                        bus.missed       <= 1'b0;
                        beep_on          <= 1'b1;
                    end
                end

                RING: begin
                    if (!bus.enable || bus.stop) begin
                        state         <= IDLE;
                        bus.ringing   <= 1'b0;
                        bus.secs_left <= '0;
                        bus.missed    <= 1'b0;
                    end else if (bus.snooze && (bus.snoozes_used < 3'(MAX_SNOOZES))) begin
                        state            <= SNOOZE;
                        bus.ringing      <= 1'b0;
                        bus.snoozing     <= 1'b1;
                        bus.secs_left    <= CNT_W'(SNOOZE_SECS);
                        bus.snoozes_used <= bus.snoozes_used + 3'd1;
                    end else if (bus.tick_1hz && (bus.secs_left == CNT_W'(1))) begin
                        state         <= IDLE;
                        bus.ringing   <= 1'b0;
                        bus.secs_left <= '0;
                        bus.missed    <= 1'b1;
                    end else begin
                        tone_cnt   <= tone_wrap ? '0 : tone_cnt + 1'b1;
                        tone       <= tone_next;
                        beep_on    <= beep_next;
                        bus.buzzer <= beep_next & tone_next;
                        if (bus.tick_1hz) begin
                            bus.secs_left <= bus.secs_left - 1'b1;
                        end
                    end
                end

                SNOOZE: begin
                    if (!bus.enable || bus.stop) begin
                        state         <= IDLE;
                        bus.snoozing  <= 1'b0;
                        bus.secs_left <= '0;
                    end else if (bus.tick_1hz) begin
                        if (bus.secs_left == CNT_W'(1)) begin
                            state         <= RING;
                            bus.ringing   <= 1'b1;
                            bus.snoozing  <= 1'b0;
                            bus.secs_left <= CNT_W'(RING_SECS);
                            beep_on       <= 1'b1;
                        end else begin
                            bus.secs_left <= bus.secs_left - 1'b1;
                        end
                    end
                end

                default: begin
                    state         <= IDLE;
                    bus.ringing   <= 1'b0;
                    bus.snoozing  <= 1'b0;
                    bus.secs_left <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alarm_ringer.sv
// Directed bench for alarm_ringer: a per-cycle vector table for the main sessions plus
// hand-written sequences for reset behaviour.
module tb_alarm_ringer;
    localparam int CNT_W = 9;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    alarm_ringer_if #(.CNT_W(CNT_W)) bus ();

    alarm_ringer #(
        .RING_SECS  (4),
        .SNOOZE_SECS(3),
        .MAX_SNOOZES(2),
        .TONE_HALF  (2),
        .CNT_W      (CNT_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit tick, hit, en, snz, stp;
        bit ring, snzg;
        int used, secs;
        bit miss;
        bit chk_buz, buz;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input bit tick, hit, en, snz, stp,
                                input bit ring, snzg, input int used, secs,
                                input bit miss, input bit chk_buz, buz);
        vec_t v;
        v.tick = tick; v.hit = hit; v.en = en; v.snz = snz; v.stp = stp;
        v.ring = ring; v.snzg = snzg; v.used = used; v.secs = secs; v.miss = miss;
        v.chk_buz = chk_buz; v.buz = buz;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit tick, hit, en, snz, stp);
        bus.tick_1hz  = tick;
        bus.alarm_hit = hit;
        bus.enable    = en;
        bus.snooze    = snz;
        bus.stop      = stp;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit seen;
        n_tests = 0;
        n_fail  = 0;

        //  tick hit en snz stp | ring snzg used secs miss chkb buz
        // Session 1: ring out unanswered, tone every 2 clks, beep toggles per tick
        add(0,1,1,0,0, 1,0,0,4,0, 1,0);
        add(0,1,1,0,0, 1,0,0,4,0, 1,0);
        add(0,1,1,0,0, 1,0,0,4,0, 1,1);
        add(0,1,1,0,0, 1,0,0,4,0, 1,1);
        add(0,1,1,0,0, 1,0,0,4,0, 1,0);
        add(1,1,1,0,0, 1,0,0,3,0, 1,0);
        add(0,1,1,0,0, 1,0,0,3,0, 1,0);
        add(1,1,1,0,0, 1,0,0,2,0, 1,1);
        add(1,1,1,0,0, 1,0,0,1,0, 1,0);
        add(1,1,1,0,0, 0,0,0,0,1, 1,0);
        add(0,1,1,0,0, 0,0,0,0,1, 1,0);
        add(0,0,1,0,0, 0,0,0,0,1, 1,0);
        // Session 2: snooze twice, third snooze ignored
        add(0,1,1,0,0, 1,0,0,4,0, 1,0);
        add(0,1,1,1,0, 0,1,1,3,0, 1,0);
        add(1,1,1,0,0, 0,1,1,2,0, 1,0);
        add(0,1,1,1,0, 0,1,1,2,0, 1,0);
        add(1,1,1,0,0, 0,1,1,1,0, 1,0);
        add(1,1,1,0,0, 1,0,1,4,0, 1,0);
        add(0,1,1,1,0, 0,1,2,3,0, 1,0);
        add(1,1,1,0,0, 0,1,2,2,0, 1,0);
        add(1,1,1,0,0, 0,1,2,1,0, 1,0);
        add(1,1,1,0,0, 1,0,2,4,0, 1,0);
        add(0,1,1,1,0, 1,0,2,4,0, 0,0);
        add(1,1,1,0,0, 1,0,2,3,0, 0,0);
        add(0,1,1,1,1, 0,0,2,0,0, 1,0);
        // Session 3: stop+snooze together, no snooze counted
        add(0,0,1,0,0, 0,0,2,0,0, 1,0);
        add(0,1,1,0,0, 1,0,0,4,0, 1,0);
        add(0,1,1,1,1, 0,0,0,0,0, 1,0);
        // Session 4: stop coincident with final tick
        add(0,0,1,0,0, 0,0,0,0,0, 1,0);
        add(0,1,1,0,0, 1,0,0,4,0, 1,0);
        add(1,1,1,0,0, 1,0,0,3,0, 0,0);
        add(1,1,1,0,0, 1,0,0,2,0, 0,0);
        add(1,1,1,0,0, 1,0,0,1,0, 0,0);
        add(1,1,1,0,1, 0,0,0,0,0, 1,0);
        // Session 5: enable low during SNOOZE, edge with enable low ignored
        add(0,0,1,0,0, 0,0,0,0,0, 1,0);
        add(0,1,1,0,0, 1,0,0,4,0, 1,0);
        add(0,1,1,1,0, 0,1,1,3,0, 1,0);
        add(0,1,0,0,0, 0,0,1,0,0, 1,0);
        add(0,0,0,0,0, 0,0,1,0,0, 1,0);
        add(0,1,0,0,0, 0,0,1,0,0, 1,0);
        add(0,1,1,0,0, 0,0,1,0,0, 1,0);

        // Reset: all outputs zero
        drive(0,0,0,0,0);
        reset = 1'b1;
        repeat (3) step();
        check("reset_buzzer",   int'(bus.buzzer),       0);
        check("reset_ringing",  int'(bus.ringing),      0);
        check("reset_snoozing", int'(bus.snoozing),     0);
        check("reset_used",     int'(bus.snoozes_used), 0);
        check("reset_secs",     int'(bus.secs_left),    0);
        check("reset_missed",   int'(bus.missed),       0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].tick, vecs[i].hit, vecs[i].en, vecs[i].snz, vecs[i].stp);
            step();
            check($sformatf("v%0d_ringing", i),  int'(bus.ringing),      int'(vecs[i].ring));
            check($sformatf("v%0d_snoozing", i), int'(bus.snoozing),     int'(vecs[i].snzg));
            check($sformatf("v%0d_used", i),     int'(bus.snoozes_used), vecs[i].used);
            check($sformatf("v%0d_secs", i),     int'(bus.secs_left),    vecs[i].secs);
            check($sformatf("v%0d_missed", i),   int'(bus.missed),       int'(vecs[i].miss));
            if (vecs[i].chk_buz)
                check($sformatf("v%0d_buzzer", i), int'(bus.buzzer), int'(vecs[i].buz));
        end

        // Reset mid-RING while the buzzer is sounding
        drive(0,0,1,0,0);
        step();
        drive(0,1,1,0,0);
        step();
        check("r6_ring_entry", int'(bus.ringing), 1);
        seen = 1'b0;
        for (int c = 0; c < 8 && !seen; c++) begin
            step();
            seen = bus.buzzer;
        end
        check("r6_buzzer_high", int'(seen), 1);
        reset = 1'b1;
        step();
        check("r6_buzzer", int'(bus.buzzer),    0);
        check("r6_ringing", int'(bus.ringing),  0);
        check("r6_secs",   int'(bus.secs_left), 0);
        reset = 1'b0;
        drive(0,0,1,0,0);
        step();
        check("r6_idle_after", int'(bus.ringing), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
